apb_regbank_slave: RTL
======================

// Module: apb_regbank_slave
// PURPOSE
//  Parametrised APB slave: NUM_REGS word registers, configurable wait states, byte strobes,
//  read-only status slots and PSLVERR. Successor to the single-register add-slave; sits
//  behind the APB add-master in the master/slave top. Exposes register contents to core logic.
// PARAMETERS
//  DATA_W       32           data width; multiple of 8
//  ADDR_W       32           paddr width
//  NUM_REGS     8            register count, >=1; word stride 4 bytes
//  BASE_ADDR    32'h0000A000 byte address of register 0
//  WAIT_CYCLES  0            extra access-phase cycles before pready; 0 = zero-wait
//  RO_MASK      '0           NUM_REGS bits; bit i=1 -> reg i read-only, sourced from ro_data_i
// PORTS
//  pclk       in   1                  APB clock
//  preset     in   1                  async active-high reset
//  psel       in   1                  APB select
//  penable    in   1                  APB enable
//  paddr      in   ADDR_W             byte address
//  pwrite     in   1                  1=write, 0=read
//  pwdata     in   DATA_W             write data
//  pstrb      in   DATA_W/8           byte write strobes
//  prdata     out  DATA_W             read data
//  pready     out  1                  transfer complete
//  pslverr    out  1                  transfer error, qualified by pready
//  ro_data_i  in   NUM_REGS*DATA_W    status values for RO slots (slot i at [i*DATA_W +: DATA_W])
//  reg_o      out  NUM_REGS*DATA_W    current RW register contents (RO slots drive 0)
// BEHAVIOUR
//  Reset (preset=1, async): state=ST_IDLE, wait counter=0, all RW regs=0; so pready=0,
//   pslverr=0, prdata=0, reg_o=0. Reset mid-transfer aborts it; no write is committed.
//  FSM: ST_IDLE -> ST_ACCESS when psel=1 (setup cycle): latch index=(paddr-BASE_ADDR)>>2,
//   err flag, cnt<=WAIT_CYCLES. ST_ACCESS: pready=(cnt==0) combinational; cnt!=0 -> cnt-1.
//   pready=1 -> commit, return ST_IDLE. psel=0 in ST_ACCESS -> ST_IDLE, no commit.
//  Latency: transfer = 2+WAIT_CYCLES cycles; back-to-back transfers need no idle cycle
//   (new setup seen in ST_IDLE cycle after completion).
//  Error (err=1) when: paddr[1:0]!=0; paddr<BASE_ADDR; paddr>=BASE_ADDR+4*NUM_REGS;
//   or write to RO slot. Error transfer: pready per wait rules, pslverr=1, no reg change, prdata=0.
//  Write: on edge with pready=1, !err: byte k of reg updated iff pstrb[k]; pstrb=0 -> no change.
//   reg_o reflects new value the cycle after the pready edge.
//  Read: prdata = reg[index] (RW) or ro_data_i slot (RO, sampled in pready cycle) when
//   pready=1 & !pwrite & !err; else 0. pslverr=0 whenever pready=0.
//  Address compare uses full ADDR_W; subtraction done unsigned at ADDR_W, no wrap accepted.
//  Counter width = max(1,$clog2(WAIT_CYCLES+1)); never underflows.
// STRUCTURE
//  apb_pkg: apb_slv_state_t {ST_IDLE, ST_ACCESS}; APB_WORD_BYTES=4; default BASE_ADDR const.
//  One sub-module: apb_wait_ctr (load/decrement counter, done flag), parametrised by WAIT_CYCLES.
//  Register array, decode and FSM stay in apb_regbank_slave.
// TESTING (NUM_REGS=8, WAIT_CYCLES=2, RO_MASK=8'h80, BASE_ADDR=0xA000)
//  Write 0xA004=0xDEADBEEF, pstrb=4'hF -> pready high exactly 3 cycles after setup... i.e.
//   on 4th transfer cycle, pslverr=0; reg_o[1]=0xDEADBEEF next cycle; read 0xA004 returns it.
//  Write 0xA008=0x11223344 pstrb=4'b0101 over 0 -> reg2=0x00220044.
//  Write 0xA01C (RO slot 7) -> pslverr=1, reg unchanged; read 0xA01C with ro_data_i slot7=0x5A5A
//   -> prdata=0x5A5A, pslverr=0.
//  Read 0xA020 and 0xA002 -> pready after 2 wait cycles, pslverr=1, prdata=0.
//  Assert preset during ST_ACCESS of write 0xA000=0xFFFFFFFF -> reg0=0, pready=0, FSM idle;
//   next transfer completes normally.
//  Two back-to-back writes 0xA00C,0xA010 without idle -> both committed, 8 cycles total.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register-bank slave and its helpers.
package apb_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } apb_slv_state_t;

    localparam int          APB_WORD_BYTES        = 4;
    localparam logic [31:0] APB_DEFAULT_BASE_ADDR = 32'h0000_A000;

endpackage

// File: rtl/apb_wait_ctr.sv
// Access-phase wait-state counter: loaded at setup, counts down to zero and holds there.
module apb_wait_ctr #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturates at zero so a stalled access phase cannot wrap the count.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/apb_regbank_slave.sv
// APB slave holding NUM_REGS word registers with byte strobes, wait states,
// read-only status slots and PSLVERR for bad addresses or writes to status slots.
module apb_regbank_slave
    import apb_pkg::*;
#(
    parameter int                   DATA_W      = 32,
    parameter int                   ADDR_W      = 32,
    parameter int                   NUM_REGS    = 8,
    parameter logic [ADDR_W-1:0]    BASE_ADDR   = ADDR_W'(APB_DEFAULT_BASE_ADDR),
    parameter int                   WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0]  RO_MASK     = '0
) (
    input  logic                         pclk,
    input  logic                         preset,
    input  logic                         psel,
    input  logic                         penable,
    input  logic [ADDR_W-1:0]            paddr,
    input  logic                         pwrite,
    input  logic [DATA_W-1:0]            pwdata,
    input  logic [DATA_W/8-1:0]          pstrb,
    output logic [DATA_W-1:0]            prdata,
    output logic                         pready,
    output logic                         pslverr,
    input  logic [NUM_REGS*DATA_W-1:0]   ro_data_i,
    output logic [NUM_REGS*DATA_W-1:0]   reg_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(APB_WORD_BYTES * NUM_REGS);

    apb_slv_state_t    state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              err_q;
    logic              wr_q;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic [ADDR_W-1:0] off;
    logic              in_range;
    logic [IDX_W-1:0]  idx_d;
    logic              err_d;
    logic              access;
    logic              cnt_done;
    logic              commit;
    logic [DATA_W-1:0] wdata_d;
    logic [DATA_W-1:0] rd_word;

    // Decode of the setup-phase address; the subtraction is only trusted once
    // paddr >= BASE_ADDR, so a wrapped offset can never look in range.
    always_comb begin
        off      = paddr - BASE_ADDR;
        in_range = (paddr >= BASE_ADDR) && (off < SPAN);
        idx_d    = off[IDX_W+1:2];
        err_d    = (paddr[1:0] != 2'b00) || !in_range ||
                   (pwrite && RO_MASK[idx_d]);
    end

    apb_wait_ctr #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_ctr (
        .clk_i  (pclk),
        .rst_i  (preset),
        .load_i ((state_q == ST_IDLE) && psel),
        .dec_i  (access),
        .done_o (cnt_done)
    );

    assign access  = (state_q == ST_ACCESS);
    assign pready  = access && psel && penable && cnt_done;
    assign pslverr = pready && err_q;
    assign commit  = pready && wr_q && !err_q;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (psel) begin
                        state_q <= ST_ACCESS;
                        idx_q   <= idx_d;
                        err_q   <= err_d;
                        wr_q    <= pwrite;
                    end
                end
                ST_ACCESS: begin
                    if (!psel || pready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wdata_d = regs_q[idx_q];
        for (int k = 0; k < STRB_W; k++) begin
            if (pstrb[k]) begin
                wdata_d[8*k +: 8] = pwdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[idx_q] <= wdata_d;
        end
    end

    // Status slots are read live from core logic in the completing cycle.
    always_comb begin
        if (RO_MASK[idx_q]) begin
            rd_word = ro_data_i[int'(idx_q)*DATA_W +: DATA_W];
        end else begin
            rd_word = regs_q[idx_q];
        end
        prdata = (pready && !wr_q && !err_q) ? rd_word : '0;
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
        assign reg_o[i*DATA_W +: DATA_W] = RO_MASK[i] ? '0 : regs_q[i];
    end

endmodule
